arith_tb_controller: RTL and testbench

Next-generation self-checking stimulus controller for arithmetic DUTs: Avalon-MM slave register file, run-control FSM, two LFSR operand generators, a latency-matched golden adder model and a result checker, all in one clock domain. It replaces the split wrapper/randomiser/driver/monitor/scoreboard arrangement. It adds programmable seed, a vector count, DUT pipeline-latency alignment, a drain phase, error counting and first-failure capture. It sits between the HPS Avalon bus and the DUT conduit.

---
 rtl/arith_tb_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_arith_tb_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_tb_controller.sv
// Self-checking stimulus controller for arithmetic DUTs.
// Holds the Avalon-MM registers, the run FSM, two LFSR operand sources,
// a latency-matched golden adder and the result checker.
// Ports:
//   clk, reset (sync, active-low)
//   slave_address, slave_read, slave_write,
//   slave_writedata, slave_readdata (Avalon-MM slave)
//   dut_a, dut_b, dut_valid (operands to DUT)
//   dut_s (DUT sum, DUT_LATENCY cycles after dut_valid)
// Optional macro TB_FAIL_CAPTURE_EN: latch the first mismatching vector
// into FAIL_A/FAIL_B/FAIL_S (indices 6..8 read 0 when undefined).
module arith_tb_controller #(
   parameter int WIDTH       = 32,
   parameter int DUT_LATENCY = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       slave_address,
   input  logic             slave_read,
   input  logic             slave_write,
   input  logic [WIDTH-1:0] slave_writedata,
   output logic [WIDTH-1:0] slave_readdata,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   output logic             dut_valid,
   input  logic [WIDTH-1:0] dut_s
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

`ifdef TB_FAIL_CAPTURE_EN
   localparam int DW = 3*WIDTH + 1;
`else
   localparam int DW = WIDTH + 1;
`endif

   state_t               state;
   logic [31:0]          seed;
   logic [31:0]          lfsr_a;
   logic [31:0]          lfsr_b;
   logic [31:0]          seed_a;
   logic [31:0]          seed_b;
   logic [CNT_WIDTH-1:0] num_vec;
   logic [CNT_WIDTH-1:0] run_num;
   logic [CNT_WIDTH-1:0] vec_cnt;
   logic [CNT_WIDTH-1:0] err_cnt;
   logic [CNT_WIDTH-1:0] err_nxt;
   logic [3:0]           drn_cnt;
   logic                 done;
   logic                 pass;
   logic                 rd_ok;
   logic                 wr_ok;
   logic                 ctrl_wr;
   logic                 start_go;
   logic                 abort_req;
   logic                 active;
   logic                 mism;
   logic [WIDTH-1:0]     exp0;
   logic [DW-1:0]        d_in;
   logic [DW-1:0]        chk;
   logic                 chk_v;
   logic [WIDTH-1:0]     chk_e;
   logic [WIDTH-1:0]     rd_mux;
   logic [WIDTH-1:0]     fail_a;
   logic [WIDTH-1:0]     fail_b;
   logic [WIDTH-1:0]     fail_s;

   function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   // An all-zero state would lock the LFSR, so substitute the default.
   function automatic logic [31:0] fix0(input logic [31:0] s);
      return (s == 32'd0) ? 32'h0000_FFFF : s;
   endfunction

   assign rd_ok     = slave_read & ~slave_write;
   assign wr_ok     = slave_write & ~slave_read;
   assign ctrl_wr   = wr_ok && (slave_address == 4'd0);
   assign abort_req = ctrl_wr & slave_writedata[1];
   assign start_go  = ctrl_wr & slave_writedata[0]
                    & ~slave_writedata[1] & (state == IDLE);
   assign active    = (state == RUN) || (state == DRAIN);
   assign seed_a    = fix0(seed);
   assign seed_b    = fix0(~seed_a);

   // Golden sum travels with its valid tag through the delay line.
   assign exp0 = dut_a + dut_b;
`ifdef TB_FAIL_CAPTURE_EN
   assign d_in = {dut_a, dut_b, exp0, dut_valid};
`else
   assign d_in = {exp0, dut_valid};
`endif

   generate
      if (DUT_LATENCY == 0) begin : g_nodly
         assign chk = d_in;
      end else begin : g_dly
         logic [DW-1:0] dl [DUT_LATENCY];
         always_ff @(posedge clk) begin
            if (!reset || start_go) begin
               for (int i = 0; i < DUT_LATENCY; i++)
                  dl[i] <= '0;
            end else begin
               dl[0] <= d_in;
               for (int i = 1; i < DUT_LATENCY; i++)
                  dl[i] <= dl[i-1];
            end
         end
         assign chk = dl[DUT_LATENCY-1];
      end
   endgenerate

   assign chk_v = chk[0];
   assign chk_e = chk[WIDTH:1];
   assign mism  = chk_v && active && (dut_s != chk_e);
   assign err_nxt = (mism && (err_cnt != '1))
                  ? err_cnt + 1'b1 : err_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         seed           <= 32'h0000_FFFF;
         num_vec        <= '0;
         run_num        <= '0;
         vec_cnt        <= '0;
         err_cnt        <= '0;
         drn_cnt        <= '0;
         done           <= 1'b0;
         pass           <= 1'b0;
         lfsr_a         <= '0;
         lfsr_b         <= '0;
         dut_a          <= '0;
         dut_b          <= '0;
         dut_valid      <= 1'b0;
         slave_readdata <= '0;
      end else begin
         if (wr_ok && slave_address == 4'd2)
            seed <= 32'(slave_writedata);
         if (wr_ok && slave_address == 4'd3)
            num_vec <= CNT_WIDTH'(slave_writedata);
         if (rd_ok)
            slave_readdata <= rd_mux;
         err_cnt <= err_nxt;
         unique case (state)
            IDLE: begin
               if (start_go) begin
                  vec_cnt <= '0;
                  err_cnt <= '0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  if (num_vec == '0) begin
                     done <= 1'b1;
                     pass <= 1'b1;
                  end else begin
                     state     <= RUN;
                     run_num   <= num_vec;
                     dut_valid <= 1'b1;
                     dut_a     <= seed_a[WIDTH-1:0];
                     dut_b     <= seed_b[WIDTH-1:0];
                     lfsr_a    <= lfsr_nx(seed_a);
                     lfsr_b    <= lfsr_nx(seed_b);
                  end
               end
            end
            RUN: begin
               // The vector on the bus this cycle counts even if aborted.
               vec_cnt <= vec_cnt + 1'b1;
               if (abort_req) begin
                  state     <= IDLE;
                  dut_valid <= 1'b0;
               end else if (CNT_WIDTH'(vec_cnt + 1'b1) == run_num) begin
                  dut_valid <= 1'b0;
                  if (DUT_LATENCY == 0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= (err_nxt == '0);
                  end else begin
                     state   <= DRAIN;
                     drn_cnt <= '0;
                  end
               end else begin
                  dut_a  <= lfsr_a[WIDTH-1:0];
                  dut_b  <= lfsr_b[WIDTH-1:0];
                  lfsr_a <= lfsr_nx(lfsr_a);
                  lfsr_b <= lfsr_nx(lfsr_b);
               end
            end
            DRAIN: begin
               if (abort_req) begin
                  state <= IDLE;
               end else if (drn_cnt == 4'(DUT_LATENCY - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
               end else begin
                  drn_cnt <= drn_cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TB_FAIL_CAPTURE_EN
   logic fail_seen;
   always_ff @(posedge clk) begin
      if (!reset || start_go) begin
         fail_seen <= 1'b0;
         fail_a    <= '0;
         fail_b    <= '0;
         fail_s    <= '0;
      end else if (mism && !fail_seen) begin
         fail_seen <= 1'b1;
         fail_a    <= chk[3*WIDTH:2*WIDTH+1];
         fail_b    <= chk[2*WIDTH:WIDTH+1];
         fail_s    <= dut_s;
      end
   end
`else
   assign fail_a = '0;
   assign fail_b = '0;
   assign fail_s = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (slave_address)
         4'd1: rd_mux = WIDTH'({28'd0, pass, done, state});
         4'd2: rd_mux = WIDTH'(seed);
         4'd3: rd_mux = WIDTH'(num_vec);
         4'd4: rd_mux = WIDTH'(vec_cnt);
         4'd5: rd_mux = WIDTH'(err_cnt);
         4'd6: rd_mux = fail_a;
         4'd7: rd_mux = fail_b;
         4'd8: rd_mux = fail_s;
         default: rd_mux = '0;
      endcase
   end

endmodule

// File: tb/tb_arith_tb_controller.sv
// Directed + randomized bench for arith_tb_controller (default params).
// Reference operands come from the Galois LFSR rule; sums from plain adds.
module tb_arith_tb_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  slave_address = '0;
   logic        slave_read = 1'b0;
   logic        slave_write = 1'b0;
   logic [31:0] slave_writedata = '0;
   logic [31:0] slave_readdata;
   logic [31:0] dut_a;
   logic [31:0] dut_b;
   logic        dut_valid;
   logic [31:0] dut_s = '0;
   logic        force_odd = 1'b0;

   int checks = 0;
   int errors = 0;

   int          w_got, w_even;
   logic [31:0] w_fa, w_fb, w_first_a, w_first_b, w_sig;
   logic [31:0] rd, sig0, cur_seed, rseed;
   int          rn;
   logic        rf;

   arith_tb_controller dut (
      .clk(clk), .reset(reset),
      .slave_address(slave_address), .slave_read(slave_read),
      .slave_write(slave_write), .slave_writedata(slave_writedata),
      .slave_readdata(slave_readdata),
      .dut_a(dut_a), .dut_b(dut_b), .dut_valid(dut_valid),
      .dut_s(dut_s)
   );

   always #5 clk = ~clk;

   // One-cycle adder DUT, optionally forcing sum bit 0 high.
   always @(posedge clk)
      dut_s <= (dut_a + dut_b) | {31'd0, force_odd};

   function automatic logic [31:0] gstep(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   function automatic logic [31:0] fix0(input logic [31:0] s);
      return (s == 0) ? 32'h0000_FFFF : s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      slave_address = a;
      slave_writedata = d;
      slave_write = 1'b1;
      @(negedge clk);
      slave_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      slave_address = a;
      slave_read = 1'b1;
      @(negedge clk);
      slave_read = 1'b0;
      d = slave_readdata;
   endtask

   // Start a run and follow dut_valid for up to 'limit' cycles, checking
   // every issued pair; optionally abort right after issue 'stop_at'.
   task automatic run(input logic [31:0] seed, input int limit,
                      input int stop_at);
      logic [31:0] ma, mb, sm;
      ma = fix0(seed);
      mb = fix0(~ma);
      w_got = 0; w_even = 0; w_fa = 0; w_fb = 0; w_sig = 0;
      w_first_a = 0; w_first_b = 0;
      bus_wr(4'd0, 32'd1);
      for (int c = 0; c < limit; c++) begin
         if (dut_valid) begin
            if (w_got == 0) begin
               w_first_a = dut_a;
               w_first_b = dut_b;
            end
            chk("dut_a", dut_a, ma);
            chk("dut_b", dut_b, mb);
            w_sig = {w_sig[30:0], w_sig[31]} ^ dut_a;
            sm = ma + mb;
            if (sm[0] == 1'b0) begin
               if (w_even == 0) begin
                  w_fa = ma;
                  w_fb = mb;
               end
               w_even++;
            end
            ma = gstep(ma);
            mb = gstep(mb);
            w_got++;
            if (stop_at != 0 && w_got == stop_at) begin
               slave_address = 4'd0;
               slave_writedata = 32'd2;
               slave_write = 1'b1;
               @(negedge clk);
               slave_write = 1'b0;
               return;
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, dut_valid}, 32'd0);
      chk("rst_a", dut_a, 32'd0);
      reset = 1'b1;
      bus_rd(4'd2, rd);
      chk("rst_seed", rd, 32'h0000_FFFF);
      bus_rd(4'd1, rd);
      chk("rst_status", rd, 32'd0);
      bus_rd(4'd3, rd);
      chk("rst_numvec", rd, 32'd0);

      // Ideal adder, 100 vectors.
      bus_wr(4'd3, 32'd100);
      run(32'h0000_FFFF, 120, 0);
      chk("ideal_issued", w_got, 32'd100);
      bus_rd(4'd4, rd);
      chk("ideal_veccnt", rd, 32'd100);
      bus_rd(4'd5, rd);
      chk("ideal_errcnt", rd, 32'd0);
      bus_rd(4'd1, rd);
      chk("ideal_status", rd, 32'hC);

      // Faulty adder forcing bit 0.
      force_odd = 1'b1;
      bus_wr(4'd3, 32'd16);
      run(32'h0000_FFFF, 30, 0);
      force_odd = 1'b0;
      chk("bad_issued", w_got, 32'd16);
      bus_rd(4'd5, rd);
      chk("bad_errcnt", rd, w_even);
      bus_rd(4'd1, rd);
      chk("bad_status", rd, (w_even > 0) ? 32'h4 : 32'hC);
`ifdef TB_FAIL_CAPTURE_EN
      bus_rd(4'd6, rd);
      chk("fail_a", rd, w_fa);
      bus_rd(4'd7, rd);
      chk("fail_b", rd, w_fb);
      bus_rd(4'd8, rd);
      chk("fail_s", rd, (w_fa + w_fb) | 32'd1);
`else
      bus_rd(4'd6, rd);
      chk("fail_a_off", rd, 32'd0);
      bus_rd(4'd8, rd);
      chk("fail_s_off", rd, 32'd0);
`endif

      // Zero seed behaves like the default seed; seed 1 starts at 1.
      bus_wr(4'd3, 32'd8);
      bus_wr(4'd2, 32'd0);
      run(32'd0, 20, 0);
      sig0 = w_sig;
      chk("seed0_issued", w_got, 32'd8);
      bus_wr(4'd2, 32'h0000_FFFF);
      run(32'h0000_FFFF, 20, 0);
      chk("seed0_vs_ffff", w_sig, sig0);
      bus_wr(4'd2, 32'd1);
      cur_seed = 32'd1;
      run(32'd1, 20, 0);
      chk("seed1_a", w_first_a, 32'd1);
      chk("seed1_b", w_first_b, 32'hFFFF_FFFE);

      // Abort after 10 of 50, then a full rerun.
      bus_wr(4'd3, 32'd50);
      run(cur_seed, 80, 10);
      chk("abort_issued", w_got, 32'd10);
      repeat (3) begin
         chk("abort_valid", {31'd0, dut_valid}, 32'd0);
         @(negedge clk);
      end
      bus_rd(4'd4, rd);
      chk("abort_veccnt", rd, 32'd10);
      bus_rd(4'd1, rd);
      chk("abort_status", rd, 32'd0);
      run(cur_seed, 70, 0);
      chk("rerun_issued", w_got, 32'd50);
      bus_rd(4'd4, rd);
      chk("rerun_veccnt", rd, 32'd50);

      // Read and write together: nothing happens.
      bus_rd(4'd3, rd);
      chk("numvec_rd", rd, 32'd50);
      @(negedge clk);
      slave_address = 4'd2;
      slave_writedata = 32'hDEAD_BEEF;
      slave_read = 1'b1;
      slave_write = 1'b1;
      @(negedge clk);
      slave_read = 1'b0;
      slave_write = 1'b0;
      chk("rw_rdata_hold", slave_readdata, 32'd50);
      bus_rd(4'd2, rd);
      chk("rw_seed_kept", rd, cur_seed);

      // Zero-length run.
      bus_wr(4'd3, 32'd0);
      run(cur_seed, 10, 0);
      chk("zero_issued", w_got, 32'd0);
      bus_rd(4'd1, rd);
      chk("zero_status", rd, 32'hC);

      // Start+abort together from IDLE does not start.
      bus_wr(4'd3, 32'd5);
      bus_wr(4'd0, 32'd3);
      repeat (4) begin
         chk("sa_valid", {31'd0, dut_valid}, 32'd0);
         @(negedge clk);
      end

      // Randomized runs against the reference model.
      repeat (4) begin
         rseed = $urandom;
         rn = $urandom_range(1, 30);
         rf = 1'($urandom_range(0, 1));
         force_odd = rf;
         bus_wr(4'd2, rseed);
         bus_wr(4'd3, 32'(rn));
         run(rseed, rn + 10, 0);
         force_odd = 1'b0;
         chk("rnd_issued", w_got, 32'(rn));
         bus_rd(4'd5, rd);
         chk("rnd_errcnt", rd, rf ? w_even : 0);
         bus_rd(4'd1, rd);
         chk("rnd_status", rd, (rf && w_even > 0) ? 32'h4 : 32'hC);
      end

      // Reset in the middle of a run.
      bus_wr(4'd2, 32'h1234_5678);
      bus_wr(4'd3, 32'd40);
      bus_wr(4'd0, 32'd1);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("mrst_valid", {31'd0, dut_valid}, 32'd0);
      chk("mrst_a", dut_a, 32'd0);
      reset = 1'b1;
      bus_rd(4'd1, rd);
      chk("mrst_status", rd, 32'd0);
      bus_rd(4'd4, rd);
      chk("mrst_veccnt", rd, 32'd0);
      bus_rd(4'd2, rd);
      chk("mrst_seed", rd, 32'h0000_FFFF);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
